// File: rtl/ds_pkg.sv
// Shared types and constants for the box-reduce downscaler.
// Holds the mode encoding, output latency and accumulator width helper.
package ds_pkg;

    typedef enum logic [1:0] {
        DS_AVG = 2'd0,
        DS_DEC = 2'd1,
        DS_MAX = 2'd2,
        DS_RSV = 2'd3
    } ds_mode_e;

    localparam int LAT = 2;

    function automatic int acc_w(input int width, input int n);
        return width + $clog2(n * n);
    endfunction

endpackage

// File: rtl/ds_chan_reduce.sv
// One channel of the NxN reducer: horizontal sum, vertical combine, divide.
// Ports: i_en/i_x0/i_y0 phase controls, i_acc/o_acc column accumulator,
//        i_emit/i_v1 pipeline strobes, o_res registered reduced value.
module ds_chan_reduce
    import ds_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int N     = 3,
    parameter int AW    = acc_w(WIDTH, N)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    input  logic             i_x0,
    input  logic             i_y0,
    input  logic             i_emit,
    input  logic             i_v1,
    input  ds_mode_e         i_mode,
    input  ds_mode_e         i_mode1,
    input  logic [WIDTH-1:0] i_pix,
    input  logic [AW-1:0]    i_acc,
    output logic [AW-1:0]    o_acc,
    output logic [WIDTH-1:0] o_res
);

    localparam logic [AW:0] NN   = (AW+1)'(N * N);
    localparam logic [AW:0] HALF = (AW+1)'((N * N) / 2);

    logic [AW-1:0]    r_hsum;
    logic [AW-1:0]    r_full;
    logic [AW-1:0]    w_pix;
    logic [AW-1:0]    w_h;
    logic [WIDTH-1:0] w_q;

    assign w_pix = AW'(i_pix);

    // Sum plus half divisor fits in AW+1 bits; quotient never exceeds WIDTH.
    assign w_q = WIDTH'(({1'b0, r_full} + HALF) / NN);

    always_comb begin
        w_h = w_pix;
        if (!i_x0) begin
            unique case (i_mode)
                DS_DEC:  w_h = r_hsum;
                DS_MAX:  w_h = (w_pix > r_hsum) ? w_pix : r_hsum;
                default: w_h = r_hsum + w_pix;
            endcase
        end
        o_acc = w_h;
        if (!i_y0) begin
            unique case (i_mode)
                DS_DEC:  o_acc = i_acc;
                DS_MAX:  o_acc = (w_h > i_acc) ? w_h : i_acc;
                default: o_acc = i_acc + w_h;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hsum <= '0;
            r_full <= '0;
            o_res  <= '0;
        end else begin
            if (i_en)
                r_hsum <= w_h;
            if (i_emit)
                r_full <= o_acc;
            if (!i_v1)
                o_res <= '0;
            else if (i_mode1 == DS_DEC || i_mode1 == DS_MAX)
                o_res <= r_full[WIDTH-1:0];
            else
                o_res <= w_q;
        end
    end

endmodule

// File: rtl/ds_box_reduce_n.sv
// Streaming NxN block downscaler using one line of column accumulators.
// Ports: i_mode/i_vsync/i_hsync/i_de/i_data video in; o_* reduced video
//        delayed by LAT; o_err sticky over-length line flag.
module ds_box_reduce_n
    import ds_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CH    = 3,
    parameter int N     = 3,
    parameter int HACT  = 1920
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          i_mode,
    input  logic                i_vsync,
    input  logic                i_hsync,
    input  logic                i_de,
    input  logic [CH*WIDTH-1:0] i_data,
    output logic                o_vsync,
    output logic                o_hsync,
    output logic                o_de,
    output logic [CH*WIDTH-1:0] o_data,
    output logic                o_err
);

    localparam int AW   = acc_w(WIDTH, N);
    localparam int CMAX = HACT / N;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int PW   = $clog2(HACT + 1);
    localparam int XW   = 3;
    localparam logic [XW-1:0] NL   = XW'(N - 1);
    localparam logic [PW-1:0] HMAX = PW'(HACT);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("ds_box_reduce_n: N must be in 2..8");
    end

    logic             r_armed, r_vs_d, r_de_d, r_err, r_v1, r_de;
    ds_mode_e         r_mode, r_mode1, w_mode;
    logic [XW-1:0]    r_x, r_y, w_x, w_y;
    logic [CW-1:0]    r_col, w_col;
    logic [PW-1:0]    r_pc, w_pc;
    logic [LAT-1:0]   r_vs_p, r_hs_p;
    logic [CH*AW-1:0] r_acc [CMAX];
    logic [CH*AW-1:0] w_rd, w_wr;
    logic [CH*WIDTH-1:0] w_res;
    logic w_rise, w_fall, w_armed, w_over, w_pix, w_xl, w_emit;

    // A frame start in the same cycle as a pixel restarts that pixel at phase 0.
    assign w_rise  = i_vsync & ~r_vs_d;
    assign w_fall  = r_de_d & ~i_de;
    assign w_armed = r_armed | w_rise;
    assign w_mode  = w_rise ? ds_mode_e'(i_mode) : r_mode;
    assign w_x     = w_rise ? '0 : r_x;
    assign w_y     = w_rise ? '0 : r_y;
    assign w_col   = w_rise ? '0 : r_col;
    assign w_pc    = w_rise ? '0 : r_pc;
    assign w_over  = w_pc >= HMAX;
    assign w_pix   = i_de & w_armed & ~w_over;
    assign w_xl    = w_x == NL;
    assign w_emit  = w_pix & w_xl & (w_y == NL);
    assign w_rd    = r_acc[w_col];

    for (genvar g = 0; g < CH; g++) begin : g_ch
        ds_chan_reduce #(
            .WIDTH (WIDTH),
            .N     (N),
            .AW    (AW)
        ) u_ch (
            .clk     (clk),
            .rstn    (rstn),
            .i_en    (w_pix),
            .i_x0    (w_x == '0),
            .i_y0    (w_y == '0),
            .i_emit  (w_emit),
            .i_v1    (r_v1),
            .i_mode  (w_mode),
            .i_mode1 (r_mode1),
            .i_pix   (i_data[(CH-g)*WIDTH-1 -: WIDTH]),
            .i_acc   (w_rd[(CH-g)*AW-1 -: AW]),
            .o_acc   (w_wr[(CH-g)*AW-1 -: AW]),
            .o_res   (w_res[(CH-g)*WIDTH-1 -: WIDTH])
        );
    end

    // Storage array: row 0 of each block overwrites, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_pix && w_xl)
            r_acc[w_col] <= w_wr;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_armed <= 1'b0;
            r_vs_d  <= 1'b0;
            r_de_d  <= 1'b0;
            r_err   <= 1'b0;
            r_v1    <= 1'b0;
            r_de    <= 1'b0;
            r_mode  <= DS_AVG;
            r_mode1 <= DS_AVG;
            r_x     <= '0;
            r_y     <= '0;
            r_col   <= '0;
            r_pc    <= '0;
            r_vs_p  <= '0;
            r_hs_p  <= '0;
        end else begin
            r_vs_d  <= i_vsync;
            r_de_d  <= i_de;
            r_vs_p  <= {r_vs_p[LAT-2:0], i_vsync};
            r_hs_p  <= {r_hs_p[LAT-2:0], i_hsync};
            r_v1    <= w_emit;
            r_mode1 <= w_mode;
            r_de    <= r_v1;
            if (w_rise) begin
                r_armed <= 1'b1;
                r_mode  <= ds_mode_e'(i_mode);
                r_err   <= 1'b0;
            end
            if (w_pix) begin
                r_pc  <= w_pc + 1'b1;
                r_x   <= w_xl ? '0 : w_x + 1'b1;
                r_col <= w_xl ? w_col + 1'b1 : w_col;
                r_y   <= w_y;
            end else if (w_rise) begin
                r_pc  <= '0;
                r_x   <= '0;
                r_col <= '0;
                r_y   <= '0;
            end else if (w_fall) begin
                r_pc  <= '0;
                r_x   <= '0;
                r_col <= '0;
                r_y   <= (r_y == NL) ? '0 : r_y + 1'b1;
            end
            if (i_de && w_armed && w_over)
                r_err <= 1'b1;
        end
    end

    assign o_vsync = r_vs_p[LAT-1];
    assign o_hsync = r_hs_p[LAT-1];
    assign o_de    = r_de;
    assign o_data  = w_res;
    assign o_err   = r_err;

endmodule

// File: tb/tb_ds_box_reduce_n.sv
// Scoreboard bench for ds_box_reduce_n with a reduced HACT.
// Expected blocks are computed from the driven image at drive time.
module tb_ds_box_reduce_n;

    localparam int W    = 10;
    localparam int CH   = 3;
    localparam int N    = 3;
    localparam int HACT = 12;
    localparam int LAT  = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [1:0]      i_mode = 2'd0;
    logic            i_vsync = 1'b0;
    logic            i_hsync = 1'b0;
    logic            i_de = 1'b0;
    logic [CH*W-1:0] i_data = '0;
    logic            o_vsync, o_hsync, o_de, o_err;
    logic [CH*W-1:0] o_data;

    ds_box_reduce_n #(
        .WIDTH (W),
        .CH    (CH),
        .N     (N),
        .HACT  (HACT)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_mode  (i_mode),
        .i_vsync (i_vsync),
        .i_hsync (i_hsync),
        .i_de    (i_de),
        .i_data  (i_data),
        .o_vsync (o_vsync),
        .o_hsync (o_hsync),
        .o_de    (o_de),
        .o_data  (o_data),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH*W-1:0] d;
        int              t;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         nvec = 0;
    int         nbad = 0;
    int         nde = 0;
    int         npush = 0;
    logic [W-1:0] img [0:7][0:15][0:CH-1];
    bit         m_armed = 1'b0;
    logic [1:0] m_mode = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CH*W-1:0] pack(input int y, input int x);
        logic [CH*W-1:0] d;
        d = '0;
        for (int c = 0; c < CH; c++)
            d[(CH-1-c)*W +: W] = img[y][x][c];
        return d;
    endfunction

    function automatic logic [CH*W-1:0] blk(input int bx, input int by,
                                            input logic [1:0] m);
        logic [CH*W-1:0] r;
        int sum, mx, p, v;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            sum = 0;
            mx  = 0;
            for (int dy = 0; dy < N; dy++)
                for (int dx = 0; dx < N; dx++) begin
                    p = int'(img[by*N+dy][bx*N+dx][c]);
                    sum += p;
                    if (p > mx) mx = p;
                end
            if (m == 2'd1)      v = int'(img[by*N][bx*N][c]);
            else if (m == 2'd2) v = mx;
            else                v = (sum + (N*N)/2) / (N*N);
            r[(CH-1-c)*W +: W] = W'(v);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rstn) begin
            if (o_de) begin
                exp_t e;
                nde++;
                if (q.size() == 0) begin
                    chk("extra_de", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("data", o_data, e.d);
                    chk("lat", 64'(cyc), 64'(e.t));
                end
            end else begin
                chk("idle_zero", o_data, '0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int kind);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 16; x++)
                for (int c = 0; c < CH; c++)
                    img[y][x][c] = (kind == 0) ? W'(100) :
                                   W'($urandom_range(0, 1023));
    endtask

    task automatic vs_start(input logic [1:0] m);
        i_mode  = m;
        i_vsync = 1'b1;
        tick();
        chk("vs_dly0", o_vsync, 1'b0);
        m_armed = 1'b1;
        m_mode  = m;
        tick();
        chk("vs_dly1", o_vsync, 1'b1);
        i_vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic line(input int y, input int w, input bit vs_first);
        i_hsync = 1'b1;
        tick();
        tick();
        i_hsync = 1'b0;
        tick();
        for (int x = 0; x < w; x++) begin
            if (vs_first && x == 0) begin
                i_vsync = 1'b1;
                m_armed = 1'b1;
                m_mode  = i_mode;
            end
            i_de   = 1'b1;
            i_data = pack(y, x);
            if (m_armed && x < HACT && x % N == N-1 && y % N == N-1) begin
                q.push_back('{blk(x/N, y/N, m_mode), cyc + LAT});
                npush++;
            end
            tick();
            i_vsync = 1'b0;
        end
        i_de   = 1'b0;
        i_data = '0;
        tick();
        tick();
    endtask

    task automatic frame(input int w, input int h, input logic [1:0] m);
        vs_start(m);
        for (int y = 0; y < h; y++)
            line(y, w, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        chk("rst_de", o_de, 1'b0);
        chk("rst_data", o_data, '0);
        chk("rst_vs", o_vsync, 1'b0);
        chk("rst_hs", o_hsync, 1'b0);
        chk("rst_err", o_err, 1'b0);
        rstn = 1'b1;
        tick();

        // disarmed: no output before the first vsync rise
        fill(1);
        for (int y = 0; y < 3; y++) line(y, 6, 1'b0);

        // constant frame, average
        fill(0);
        frame(6, 6, 2'd0);
        chk("err_clear", o_err, 1'b0);

        // rounding and full-scale
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++) begin
                img[y][x][0] = (y*3 + x < 4) ? W'(1) : W'(0);
                img[y][x][1] = (y*3 + x < 5) ? W'(1) : W'(0);
                img[y][x][2] = W'(1023);
            end
        frame(3, 3, 2'd0);

        // decimate, max with a single peak, reserved mode as average
        fill(1);
        frame(6, 6, 2'd1);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                for (int c = 0; c < CH; c++)
                    img[y][x][c] = W'(10);
        img[1][2][0] = W'(900);
        img[2][1][1] = W'(900);
        img[0][0][2] = W'(900);
        frame(3, 3, 2'd2);
        fill(1);
        frame(6, 6, 2'd3);

        // partial groups discarded
        fill(1);
        frame(7, 7, 2'd0);

        // over-length line
        fill(1);
        vs_start(2'd2);
        for (int y = 0; y < 3; y++) line(y, HACT + 2, 1'b0);
        chk("err_set", o_err, 1'b1);
        vs_start(2'd0);
        chk("err_vs_clr", o_err, 1'b0);

        // reset mid-frame
        fill(1);
        vs_start(2'd0);
        for (int y = 0; y < 4; y++) line(y, 6, 1'b0);
        i_de   = 1'b1;
        i_data = pack(4, 0);
        tick();
        rstn = 1'b0;
        #2;
        chk("mrst_de", o_de, 1'b0);
        chk("mrst_data", o_data, '0);
        chk("mrst_vs", o_vsync, 1'b0);
        chk("mrst_err", o_err, 1'b0);
        m_armed = 1'b0;
        tick();
        i_de = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        for (int y = 4; y < 6; y++) line(y, 6, 1'b0);
        frame(6, 6, 2'd0);

        // mode change mid-frame applies only at the next frame
        fill(1);
        vs_start(2'd0);
        line(0, 6, 1'b0);
        i_mode = 2'd2;
        for (int y = 1; y < 6; y++) line(y, 6, 1'b0);
        fill(1);
        frame(6, 6, i_mode);

        // vsync rise together with the first pixel
        fill(1);
        i_mode = 2'd1;
        line(0, 6, 1'b1);
        for (int y = 1; y < 6; y++) line(y, 6, 1'b0);

        repeat (5) tick();
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("de_count", 64'(nde), 64'(npush));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
